// File: rtl/mux_pkg.sv
// Shared types and defaults for the round-robin valid/ready multiplexer.
// Optional burst limit is enabled by defining MUX_BURST_LIMIT_EN.
package mux_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefNumCh      = 4;
  localparam int unsigned DefIdleCycles = 3;
  localparam int unsigned DefMaxBurst   = 4;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_ch_i,
// wrapping modulo NUM_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  localparam int unsigned CH_W  = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_ch_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   grant_idx_o,
  output logic              any_req_o
);

  logic            found;
  logic [CH_W-1:0] idx_c;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx_c       = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx_c = CH_W'((32'(last_ch_i) + k) % NUM_CH);
      if (!found && req_i[idx_c]) begin
        found          = 1'b1;
        grant_o[idx_c] = 1'b1;
        grant_idx_o    = idx_c;
      end
    end
  end

  assign any_req_o = found;

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 valid/ready multiplexer with round-robin arbitration and per-channel burst lock.
// Define MUX_BURST_LIMIT_EN to force rotation after MAX_BURST beats of one lock.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned NUM_CH      = DefNumCh,
  parameter int unsigned IDLE_CYCLES = DefIdleCycles,
  parameter int unsigned MAX_BURST   = DefMaxBurst,
  localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]              ch_out,
  output logic                         valid_out,
  input  logic                         ready_out
);

  state_e                state_q, state_d;
  logic [3:0]            idle_cnt_q, idle_cnt_d;
  logic [CH_W-1:0]       last_ch_q, last_ch_d;
  logic [CH_W-1:0]       lock_ch_q, lock_ch_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  valid_q, valid_d;

  logic                  slot_free;
  logic                  accept;
  logic                  rot_hold;
  logic [NUM_CH-1:0]     arb_req, arb_grant, grant, lock_oh;
  logic [CH_W-1:0]       arb_idx, sel_idx;
  logic                  arb_any;

  assign slot_free = !valid_q || ready_out;
  assign lock_oh   = NUM_CH'(1) << lock_ch_q;
  // A forced rotation blanks the arbiter for one cycle to create the bubble.
  assign arb_req   = rot_hold ? '0 : valid_in;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req_i      (arb_req),
    .last_ch_i  (last_ch_q),
    .grant_o    (arb_grant),
    .grant_idx_o(arb_idx),
    .any_req_o  (arb_any)
  );

  always_comb begin
    grant   = '0;
    sel_idx = '0;
    unique case (state_q)
      SYNC: begin
        grant   = '0;
        sel_idx = '0;
      end
      IDLE: begin
        grant   = arb_any ? arb_grant : '0;
        sel_idx = arb_idx;
      end
      LOCK: begin
        grant   = lock_oh;
        sel_idx = lock_ch_q;
      end
      default: begin
        grant   = '0;
        sel_idx = '0;
      end
    endcase
  end

  assign ready_in = (state_q != SYNC && slot_free) ? grant : '0;
  assign accept   = |(valid_in & ready_in);

`ifdef MUX_BURST_LIMIT_EN
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       hold_q, hold_d;

  assign rot_hold = hold_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      burst_cnt_q <= '0;
      hold_q      <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      hold_q      <= hold_d;
    end
  end
`else
  logic unused_max_burst;

  assign rot_hold         = 1'b0;
  assign unused_max_burst = ^MAX_BURST;
`endif

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    last_ch_d  = last_ch_q;
    lock_ch_d  = lock_ch_q;
`ifdef MUX_BURST_LIMIT_EN
    burst_cnt_d = burst_cnt_q;
    hold_d      = 1'b0;
`endif
    unique case (state_q)
      SYNC: begin
        if (|valid_in) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == 4'(IDLE_CYCLES - 1)) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_d   = LOCK;
          lock_ch_d = arb_idx;
`ifdef MUX_BURST_LIMIT_EN
          burst_cnt_d = 8'd1;
          if (MAX_BURST == 1) begin
            state_d   = IDLE;
            last_ch_d = arb_idx;
            hold_d    = 1'b1;
          end
`endif
        end
      end
      LOCK: begin
        if (slot_free) begin
          // Lock owner went quiet: release, and this edge moves no beat.
          if (!valid_in[lock_ch_q]) begin
            state_d   = IDLE;
            last_ch_d = lock_ch_q;
          end
`ifdef MUX_BURST_LIMIT_EN
          else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
            if (burst_cnt_d == 8'(MAX_BURST)) begin
              state_d   = IDLE;
              last_ch_d = lock_ch_q;
              hold_d    = 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = data_in[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
      ch_d    = sel_idx;
      valid_d = 1'b1;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SYNC;
      idle_cnt_q <= '0;
      last_ch_q  <= CH_W'(NUM_CH - 1);
      lock_ch_q  <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      last_ch_q  <= last_ch_d;
      lock_ch_q  <= lock_ch_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign ch_out    = ch_q;
  assign valid_out = valid_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(ready_in));
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset_L)
    (valid_out && !ready_out) |=> (valid_out && $stable(data_out) && $stable(ch_out)));

endmodule
